// File: rtl/freepdk45_sram_1rw1r_wmask.sv
// Behavioural 1RW (lane-masked write) + 1R SRAM with registered requests and registered read data.
// Define SRAM_INIT_CLEAR_EN to build the post-reset clear sequencer that writes INIT_VALUE to every word.
module freepdk45_sram_1rw1r_wmask #(
   parameter int                    DATA_WIDTH  = 64,
   parameter int                    ADDR_WIDTH  = 9,
   parameter int                    WMASK_WIDTH = 8,
   parameter logic [DATA_WIDTH-1:0] INIT_VALUE  = '0,
   parameter int                    VERBOSE     = 1
) (
   input  logic                   clk0,
   input  logic                   rstb,
   output logic                   ready,
   input  logic                   csb0,
   input  logic                   web0,
   input  logic [WMASK_WIDTH-1:0] wmask0,
   input  logic [ADDR_WIDTH-1:0]  addr0,
   input  logic [DATA_WIDTH-1:0]  din0,
   output logic [DATA_WIDTH-1:0]  dout0,
   input  logic                   csb1,
   input  logic [ADDR_WIDTH-1:0]  addr1,
   output logic [DATA_WIDTH-1:0]  dout1,
   output logic                   collision,
   output logic                   dbg_state
);

   localparam int RAM_DEPTH  = 1 << ADDR_WIDTH;
   localparam int LANE_WIDTH = DATA_WIDTH / WMASK_WIDTH;

   // VERBOSE only selects model logging level; the lane split must divide the word exactly.
   if ((DATA_WIDTH % WMASK_WIDTH) != 0 || VERBOSE < 0 || $bits(INIT_VALUE) != DATA_WIDTH)
   begin : g_cfg_invalid
   end

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_IDLE = 1'b1
   } state_t;

   state_t state;
   assign dbg_state = state;

   logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

`ifdef SRAM_INIT_CLEAR_EN
   localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = '1;
   logic [ADDR_WIDTH-1:0] clr_addr;
`endif

   always_ff @(posedge clk0 or negedge rstb) begin
      if (!rstb) begin
         state    <= ST_INIT;
         ready    <= 1'b0;
`ifdef SRAM_INIT_CLEAR_EN
         clr_addr <= '0;
`endif
      end else begin
         case (state)
            ST_INIT: begin
`ifdef SRAM_INIT_CLEAR_EN
               clr_addr <= clr_addr + 1'b1;
               if (clr_addr == ADDR_LAST) begin
                  state <= ST_IDLE;
                  ready <= 1'b1;
               end
`else
               state <= ST_IDLE;
               ready <= 1'b1;
`endif
            end
            default: begin
               state <= ST_IDLE;
               ready <= 1'b1;
            end
         endcase
      end
   end

   // A request (csbN=0) is taken at a rising edge only while ready=1; once ready is high there is
   // no back-pressure, and its result appears one edge later.
   logic                   s1_csb0;
   logic                   s1_web0;
   logic [WMASK_WIDTH-1:0] s1_wmask0;
   logic [ADDR_WIDTH-1:0]  s1_addr0;
   logic [DATA_WIDTH-1:0]  s1_din0;
   logic                   s1_csb1;
   logic [ADDR_WIDTH-1:0]  s1_addr1;

   always_ff @(posedge clk0 or negedge rstb) begin
      if (!rstb) begin
         s1_csb0   <= 1'b1;
         s1_web0   <= 1'b1;
         s1_wmask0 <= '0;
         s1_addr0  <= '0;
         s1_din0   <= '0;
         s1_csb1   <= 1'b1;
         s1_addr1  <= '0;
      end else begin
         s1_csb0   <= csb0 | ~ready;
         s1_web0   <= web0;
         s1_wmask0 <= wmask0;
         s1_addr0  <= addr0;
         s1_din0   <= din0;
         s1_csb1   <= csb1 | ~ready;
         s1_addr1  <= addr1;
      end
   end

   logic wr0;
   logic rd0;
   logic rd1;

   assign wr0 = !s1_csb0 && !s1_web0;
   assign rd0 = !s1_csb0 &&  s1_web0;
   assign rd1 = !s1_csb1;

   // Array has no reset so contents survive rstb; the clear write is held off while rstb is low.
   always_ff @(posedge clk0) begin
`ifdef SRAM_INIT_CLEAR_EN
      if (rstb && state == ST_INIT) begin
         mem[clr_addr] <= INIT_VALUE;
      end
`endif
      if (wr0) begin
         for (int i = 0; i < WMASK_WIDTH; i++) begin
            if (s1_wmask0[i]) begin
               mem[s1_addr0][i*LANE_WIDTH +: LANE_WIDTH] <= s1_din0[i*LANE_WIDTH +: LANE_WIDTH];
            end
         end
      end
   end

   // Reads sample the array before this edge's write lands, giving read-before-write on port 1.
   always_ff @(posedge clk0 or negedge rstb) begin
      if (!rstb) begin
         dout0     <= '0;
         dout1     <= '0;
         collision <= 1'b0;
      end else begin
         if (rd0) begin
            dout0 <= mem[s1_addr0];
         end
         if (rd1) begin
            dout1 <= mem[s1_addr1];
         end
         collision <= wr0 && rd1 && (s1_addr0 == s1_addr1);
      end
   end

endmodule

// File: tb/tb_freepdk45_sram_1rw1r_wmask.sv
// Directed bench for freepdk45_sram_1rw1r_wmask: table of single-request vectors plus hand-written
// multi-cycle sequences (collision, hold, back-to-back, reset during read / during clear).
`timescale 1ns/1ps
module tb_freepdk45_sram_1rw1r_wmask;

   localparam int DW = 64;
   localparam int AW = 9;
   localparam int MW = 8;

`ifdef SRAM_INIT_CLEAR_EN
   localparam int          INIT_EDGES = 512;
   localparam logic [DW-1:0] RET_005  = 64'h0;
   localparam logic [DW-1:0] RET_020  = 64'h0;
`else
   localparam int          INIT_EDGES = 1;
   localparam logic [DW-1:0] RET_005  = 64'h0123_4567_89AB_CDFF;
   localparam logic [DW-1:0] RET_020  = 64'hAA11_AA22_33AA_44AA;
`endif

   logic          clk0 = 1'b0;
   logic          rstb;
   logic          ready;
   logic          csb0;
   logic          web0;
   logic [MW-1:0] wmask0;
   logic [AW-1:0] addr0;
   logic [DW-1:0] din0;
   logic [DW-1:0] dout0;
   logic          csb1;
   logic [AW-1:0] addr1;
   logic [DW-1:0] dout1;
   logic          collision;
   logic          dbg_state;

   int n_checks = 0;
   int n_fail   = 0;
   logic [DW-1:0] exp_q[$];

   always #5 clk0 = ~clk0;

   freepdk45_sram_1rw1r_wmask dut (
      .clk0      (clk0),
      .rstb      (rstb),
      .ready     (ready),
      .csb0      (csb0),
      .web0      (web0),
      .wmask0    (wmask0),
      .addr0     (addr0),
      .din0      (din0),
      .dout0     (dout0),
      .csb1      (csb1),
      .addr1     (addr1),
      .dout1     (dout1),
      .collision (collision),
      .dbg_state (dbg_state)
   );

   typedef struct packed {
      logic          csb0;
      logic          web0;
      logic [MW-1:0] wmask0;
      logic [AW-1:0] addr0;
      logic [DW-1:0] din0;
      logic          csb1;
      logic [AW-1:0] addr1;
      logic [DW-1:0] exp_dout0;
      logic [DW-1:0] exp_dout1;
      logic          exp_coll;
   } vec_t;

   localparam int NV = 10;
   vec_t vecs [NV];

   function automatic vec_t mk(input logic c0, input logic w0, input logic [MW-1:0] m0,
                               input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                               input logic c1, input logic [AW-1:0] a1,
                               input logic [DW-1:0] e0, input logic [DW-1:0] e1, input logic ec);
      vec_t v;
      v.csb0 = c0; v.web0 = w0; v.wmask0 = m0; v.addr0 = a0; v.din0 = d0;
      v.csb1 = c1; v.addr1 = a1;
      v.exp_dout0 = e0; v.exp_dout1 = e1; v.exp_coll = ec;
      return v;
   endfunction

   task automatic tick();
      @(posedge clk0);
      #1;
   endtask

   // Deselected ports get random address/data/mask so a leaking deselect would corrupt the array.
   task automatic idle_inputs();
      csb0   = 1'b1;
      csb1   = 1'b1;
      web0   = 1'($urandom_range(0, 1));
      wmask0 = MW'($urandom_range(0, 255));
      addr0  = AW'($urandom_range(0, 511));
      addr1  = AW'($urandom_range(0, 511));
      din0   = {$urandom(), $urandom()};
   endtask

   task automatic p0_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [MW-1:0] m);
      csb0 = 1'b0; web0 = 1'b0; addr0 = a; din0 = d; wmask0 = m;
   endtask

   task automatic p0_read(input logic [AW-1:0] a);
      csb0 = 1'b0; web0 = 1'b1; addr0 = a;
   endtask

   task automatic p1_read(input logic [AW-1:0] a);
      csb1 = 1'b0; addr1 = a;
   endtask

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_bit(input string name, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic wait_ready(input string name, input int exp_edges);
      int cnt;
      cnt = 0;
      while (ready !== 1'b1 && cnt < 2000) begin
         tick();
         cnt++;
      end
      check(name, DW'(cnt), DW'(exp_edges));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = mk(0, 0, 8'hFF, 9'h005, 64'h0123_4567_89AB_CDEF, 1, 9'h000,
                   64'h0, 64'h0, 0);
      vecs[1] = mk(0, 0, 8'h01, 9'h005, 64'hFFFF_FFFF_FFFF_FFFF, 1, 9'h000,
                   64'h0, 64'h0, 0);
      vecs[2] = mk(0, 1, 8'h00, 9'h005, 64'h0, 0, 9'h005,
                   64'h0123_4567_89AB_CDFF, 64'h0123_4567_89AB_CDFF, 0);
      vecs[3] = mk(0, 0, 8'hFF, 9'h020, 64'h1111_2222_3333_4444, 1, 9'h000,
                   64'h0123_4567_89AB_CDFF, 64'h0123_4567_89AB_CDFF, 0);
      vecs[4] = mk(0, 0, 8'hA5, 9'h020, 64'hAAAA_AAAA_AAAA_AAAA, 0, 9'h020,
                   64'h0123_4567_89AB_CDFF, 64'h1111_2222_3333_4444, 1);
      vecs[5] = mk(0, 0, 8'h00, 9'h020, 64'h0, 1, 9'h000,
                   64'h0123_4567_89AB_CDFF, 64'h1111_2222_3333_4444, 0);
      vecs[6] = mk(0, 1, 8'h00, 9'h020, 64'h0, 0, 9'h005,
                   64'hAA11_AA22_33AA_44AA, 64'h0123_4567_89AB_CDFF, 0);
      vecs[7] = mk(0, 0, 8'hFF, 9'h021, 64'h0F0E_0D0C_0B0A_0908, 0, 9'h020,
                   64'hAA11_AA22_33AA_44AA, 64'hAA11_AA22_33AA_44AA, 0);
      vecs[8] = mk(0, 0, 8'h80, 9'h021, 64'hFFFF_FFFF_FFFF_FFFF, 0, 9'h021,
                   64'hAA11_AA22_33AA_44AA, 64'h0F0E_0D0C_0B0A_0908, 1);
      vecs[9] = mk(0, 1, 8'h00, 9'h021, 64'h0, 1, 9'h000,
                   64'hFF0E_0D0C_0B0A_0908, 64'h0F0E_0D0C_0B0A_0908, 0);

      // Reset state and clear/ready timing
      rstb = 1'b0;
      idle_inputs();
      repeat (3) tick();
      check_bit("rst_ready", ready, 1'b0);
      check("rst_dout0", dout0, 64'h0);
      check("rst_dout1", dout1, 64'h0);
      check_bit("rst_collision", collision, 1'b0);
      rstb = 1'b1;
      check_bit("ready_low_at_release", ready, 1'b0);
      wait_ready("init_edges", INIT_EDGES);

`ifdef SRAM_INIT_CLEAR_EN
      p1_read(9'h1FF);
      tick();
      idle_inputs();
      tick();
      check("cleared_word_1ff", dout1, 64'h0);
`endif

      // Single-request vectors: request edge, then one idle edge, then compare
      for (int i = 0; i < NV; i++) begin
         csb0 = vecs[i].csb0; web0 = vecs[i].web0; wmask0 = vecs[i].wmask0;
         addr0 = vecs[i].addr0; din0 = vecs[i].din0;
         csb1 = vecs[i].csb1; addr1 = vecs[i].addr1;
         tick();
         idle_inputs();
         tick();
         check($sformatf("vec%0d_dout0", i), dout0, vecs[i].exp_dout0);
         check($sformatf("vec%0d_dout1", i), dout1, vecs[i].exp_dout1);
         check_bit($sformatf("vec%0d_collision", i), collision, vecs[i].exp_coll);
      end

      // Collision followed immediately by a read of the same word
      p0_write(9'h010, 64'h0, 8'hFF);
      tick();
      idle_inputs();
      tick();
      p0_write(9'h010, 64'hAAAA_AAAA_AAAA_AAAA, 8'hFF);
      p1_read(9'h010);
      tick();
      csb0 = 1'b1;
      p1_read(9'h010);
      tick();
      check("coll_old_data", dout1, 64'h0);
      check_bit("coll_pulse", collision, 1'b1);
      idle_inputs();
      tick();
      check("coll_new_data", dout1, 64'hAAAA_AAAA_AAAA_AAAA);
      check_bit("coll_cleared", collision, 1'b0);

      // Port 0 hold while deselected
      p0_read(9'h005);
      tick();
      idle_inputs();
      tick();
      check("hold_first", dout0, 64'h0123_4567_89AB_CDFF);
      for (int k = 0; k < 3; k++) begin
         idle_inputs();
         tick();
         check($sformatf("hold_idle%0d", k), dout0, 64'h0123_4567_89AB_CDFF);
      end
      p0_read(9'h005);
      tick();
      idle_inputs();
      tick();
      check("deselect_no_write", dout0, 64'h0123_4567_89AB_CDFF);

      // Write at edge N, read at edge N+1
      p0_write(9'h040, 64'h5A5A_0000_FFFF_1234, 8'hFF);
      exp_q.push_back(64'h5A5A_0000_FFFF_1234);
      tick();
      p0_read(9'h040);
      p1_read(9'h040);
      tick();
      idle_inputs();
      tick();
      check("b2b_dout1", dout1, exp_q[0]);
      check("b2b_dout0", dout0, exp_q.pop_front());

      // Reset with a read pending in stage 1
      p0_read(9'h005);
      tick();
      rstb = 1'b0;
      #1;
      check("async_rst_dout0", dout0, 64'h0);
      check_bit("async_rst_ready", ready, 1'b0);
      idle_inputs();
      tick();
      tick();
      rstb = 1'b1;
      wait_ready("reinit_edges", INIT_EDGES);
      check("pending_read_dropped", dout0, 64'h0);
      p0_read(9'h005);
      tick();
      idle_inputs();
      tick();
      check("post_reset_word_005", dout0, RET_005);

`ifdef SRAM_INIT_CLEAR_EN
      // Reset in the middle of the clear sweep restarts it from address 0
      repeat (200) tick();
      check_bit("mid_clear_ready", ready, 1'b1);
      rstb = 1'b0;
      tick();
      rstb = 1'b1;
      repeat (200) tick();
      check_bit("mid_clear_not_ready", ready, 1'b0);
      rstb = 1'b0;
      tick();
      rstb = 1'b1;
      wait_ready("restart_clear_edges", INIT_EDGES);
`endif

      p1_read(9'h020);
      tick();
      idle_inputs();
      tick();
      check("final_word_020", dout1, RET_020);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
